// File: rtl/render_frame_sync.sv
// rtl/render_frame_sync.sv - frame barrier and launcher for parallel renderer channels
//
// Launches one frame at a time on all enabled renderer channels. It waits until
// every channel in the latched mask reports a rising frame_done, then launches
// the next frame. A channel that hangs is forced through by a cycle timeout.
// The block also keeps an animation timer, a frame counter and the length of
// the last frame in cycles.
//
// Ports:
//   clk_in            renderer clock
//   rst_n_in          asynchronous active-low reset
//   enable_in         0 blocks new launches
//   mode_in           0 free-run, 1 single-step, 2/3 hold
//   step_in           single-step request, sampled in IDLE
//   ch_mask_in        participating channels, latched at launch
//   done_in           per-channel frame_done levels
//   clr_in            clears timed_out_ch_out
//   start_out         one-cycle launch pulse
//   busy_out          frame in flight
//   timer_out         animation timer, advances once per launch
//   frame_count_out   completed frames (normal or forced)
//   frame_cycles_out  length of the last frame, saturating
//   timeout_out       one-cycle pulse on forced completion
//   timed_out_ch_out  sticky per-channel missed-deadline flags
module render_frame_sync #(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned TIMER_W        = 32,
    parameter int unsigned FCNT_W         = 16,
    parameter int unsigned CYC_W          = 24,
    parameter int unsigned TIMEOUT_CYCLES = 2**22
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               enable_in,
    input  logic [1:0]         mode_in,
    input  logic               step_in,
    input  logic [N_CH-1:0]    ch_mask_in,
    input  logic [N_CH-1:0]    done_in,
    input  logic               clr_in,
    output logic               start_out,
    output logic               busy_out,
    output logic [TIMER_W-1:0] timer_out,
    output logic [FCNT_W-1:0]  frame_count_out,
    output logic [CYC_W-1:0]   frame_cycles_out,
    output logic               timeout_out,
    output logic [N_CH-1:0]    timed_out_ch_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Last cyc value of a frame before it is forced through.
    localparam int unsigned     TO_M1   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TO_M1);

    state_t            state;
    logic [N_CH-1:0]   mask_q;
    logic [N_CH-1:0]   done_q;
    logic [N_CH-1:0]   done_seen;
    logic [CYC_W-1:0]  cyc;

    logic [N_CH-1:0]   done_rise;
    logic [N_CH-1:0]   seen_now;
    logic [N_CH-1:0]   to_set;
    logic [CYC_W-1:0]  cyc_inc;
    logic              complete;
    logic              timeout_hit;
    logic              finish;
    logic              launch_idle;
    logic              relaunch;

    always_comb begin
        done_rise   = done_in & ~done_q;
        // Include this cycle's rises so a completing edge is acted on at once.
        seen_now    = done_seen | done_rise;
        complete    = &(seen_now | ~mask_q);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc == TO_LAST) && !complete;
        finish      = (state == RUN) && (complete || timeout_hit);
        cyc_inc     = (&cyc) ? cyc : cyc + 1'b1;
        launch_idle = enable_in && ((mode_in == 2'd0) || ((mode_in == 2'd1) && step_in));
        relaunch    = enable_in && (mode_in == 2'd0);
        to_set      = '0;
        if ((state == RUN) && timeout_hit) begin
            to_set = mask_q & ~seen_now;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            mask_q           <= '0;
            done_q           <= '0;
            done_seen        <= '0;
            cyc              <= '0;
            start_out        <= 1'b0;
            busy_out         <= 1'b0;
            timer_out        <= '0;
            frame_count_out  <= '0;
            frame_cycles_out <= '0;
            timeout_out      <= 1'b0;
            timed_out_ch_out <= '0;
        end else begin
            done_q      <= done_in;
            start_out   <= 1'b0;
            timeout_out <= 1'b0;
            // A new missed deadline in the same cycle as clr_in must survive.
            timed_out_ch_out <= (clr_in ? '0 : timed_out_ch_out) | to_set;

            case (state)
                IDLE: begin
                    if (launch_idle) begin
                        state     <= START;
                        start_out <= 1'b1;
                    end
                end
                START: begin
                    mask_q    <= ch_mask_in;
                    done_seen <= '0;
                    cyc       <= '0;
                    timer_out <= timer_out + 1'b1;
                    state     <= RUN;
                    busy_out  <= 1'b1;
                end
                RUN: begin
                    done_seen <= seen_now;
                    cyc       <= cyc_inc;
                    if (finish) begin
                        frame_count_out  <= frame_count_out + 1'b1;
                        frame_cycles_out <= cyc_inc;
                        timeout_out      <= timeout_hit;
                        busy_out         <= 1'b0;
                        if (relaunch) begin
                            state     <= START;
                            start_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_frame_sync.sv
// tb/tb_render_frame_sync.sv - self-checking bench for render_frame_sync
module tb_render_frame_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic        step;
    logic [1:0]  ch_mask;
    logic [1:0]  done;
    logic        clr;
    logic        start_out;
    logic        busy_out;
    logic [31:0] timer_out;
    logic [15:0] frame_count_out;
    logic [23:0] frame_cycles_out;
    logic        timeout_out;
    logic [1:0]  timed_out_ch_out;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int base;
    logic [15:0] prev_fcnt = '0;

    typedef struct {
        logic [15:0] fcnt;
        logic [23:0] fcyc;
        logic        to;
        logic [1:0]  toch;
        logic [31:0] timer;
    } exp_t;

    exp_t sb[$];

    render_frame_sync #(
        .N_CH(2), .TIMER_W(32), .FCNT_W(16), .CYC_W(24), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable), .mode_in(mode),
        .step_in(step), .ch_mask_in(ch_mask), .done_in(done), .clr_in(clr),
        .start_out(start_out), .busy_out(busy_out), .timer_out(timer_out),
        .frame_count_out(frame_count_out), .frame_cycles_out(frame_cycles_out),
        .timeout_out(timeout_out), .timed_out_ch_out(timed_out_ch_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int fcnt, input int fcyc, input logic to,
                            input logic [1:0] toch, input int timer);
        exp_t e;
        e.fcnt  = 16'(fcnt);
        e.fcyc  = 24'(fcyc);
        e.to    = to;
        e.toch  = toch;
        e.timer = 32'(timer);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (start_out !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq("start_seen", {63'd0, start_out}, 64'd1);
    endtask

    // Completion monitor: every frame_count change pops one expected frame result.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fcnt = '0;
        end else begin
            if (start_out) start_cnt++;
            if (frame_count_out != prev_fcnt) begin
                prev_fcnt = frame_count_out;
                if (sb.size() == 0) begin
                    check_eq("unexpected_completion", 64'(frame_count_out), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("frame_count", 64'(frame_count_out), 64'(e.fcnt));
                    check_eq("frame_cycles", 64'(frame_cycles_out), 64'(e.fcyc));
                    check_eq("timeout_pulse", 64'(timeout_out), 64'(e.to));
                    check_eq("timed_out_ch", 64'(timed_out_ch_out), 64'(e.toch));
                    check_eq("timer", 64'(timer_out), 64'(e.timer));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 {27'd0, start_out, busy_out, timeout_out, timed_out_ch_out,
                  timer_out != 0, frame_count_out != 0, frame_cycles_out != 0},
                 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; step = 1'b0;
        ch_mask = 2'b11; done = 2'b00; clr = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        // Frame 1: both channels, done[0] at cycle 5, done[1] at cycle 9.
        rst_n = 1'b1; enable = 1'b1;
        wait_start(5);
        push_exp(1, 10, 1'b0, 2'b00, 1);
        tick();
        check_eq("f1_timer", 64'(timer_out), 64'd1);
        check_eq("f1_busy", 64'(busy_out), 64'd1);
        check_eq("f1_start_1cyc", 64'(start_out), 64'd0);
        repeat (5) tick();
        done[0] = 1'b1;
        repeat (4) tick();
        done[1] = 1'b1;
        tick();
        check_eq("f1_relaunch", 64'(start_out), 64'd1);
        check_eq("f1_busy_low", 64'(busy_out), 64'd0);

        // Frame 2: done[0] stays high from frame 1, so only a timeout ends it.
        done[1] = 1'b0;
        push_exp(2, 16, 1'b1, 2'b01, 2);
        tick();
        repeat (3) tick();
        done[1] = 1'b1;
        tick();
        done[1] = 1'b0; done[0] = 1'b0; ch_mask = 2'b10;
        repeat (11) tick();
        check_eq("f2_no_early_to", 64'(timeout_out), 64'd0);
        check_eq("f2_busy", 64'(busy_out), 64'd1);
        tick();
        check_eq("f2_relaunch", 64'(start_out), 64'd1);
        check_eq("f2_timeout", 64'(timeout_out), 64'd1);

        // Frame 3: mask 10, clear the sticky, only done[1] pulses.
        tick();
        check_eq("f2_timeout_1cyc", 64'(timeout_out), 64'd0);
        check_eq("f2_sticky", 64'(timed_out_ch_out), 64'b01);
        clr = 1'b1;
        push_exp(3, 5, 1'b0, 2'b00, 3);
        tick();
        clr = 1'b0;
        check_eq("clr_sticky", 64'(timed_out_ch_out), 64'd0);
        tick();
        ch_mask = 2'b00;
        push_exp(4, 1, 1'b0, 2'b00, 4);
        push_exp(5, 1, 1'b0, 2'b00, 5);
        push_exp(6, 1, 1'b0, 2'b00, 6);
        repeat (2) tick();
        done[1] = 1'b1;
        // Empty mask: a launch every second cycle until mode 2 stops it.
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) done[1] = 1'b0;
            if (i == 4) mode = 2'd2;
            check_eq($sformatf("free_start_%0d", i), 64'(start_out),
                     (i < 6 && i % 2 == 0) ? 64'd1 : 64'd0);
        end
        check_eq("hold_busy", 64'(busy_out), 64'd0);
        base = start_cnt;
        repeat (5) tick();
        check_eq("mode2_no_start", 64'(start_cnt - base), 64'd0);

        // Single step: one pulse of step_in gives exactly one frame.
        mode = 2'd1; ch_mask = 2'b10; step = 1'b1;
        base = start_cnt;
        tick();
        step = 1'b0;
        check_eq("step_start", 64'(start_out), 64'd1);
        push_exp(7, 3, 1'b0, 2'b00, 7);
        tick();
        repeat (2) tick();
        done[1] = 1'b1;
        tick();
        done[1] = 1'b0;
        check_eq("step_idle", 64'(start_out), 64'd0);
        repeat (6) tick();
        check_eq("step_one_start", 64'(start_cnt - base), 64'd1);

        // Frame 8: last done rise lands on the timeout cycle; completion wins.
        mode = 2'd0; ch_mask = 2'b11;
        wait_start(5);
        push_exp(8, 16, 1'b0, 2'b00, 8);
        tick();
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        repeat (14) tick();
        done[1] = 1'b1;
        tick();
        done[1] = 1'b0;
        check_eq("same_cycle_no_to", 64'(timeout_out), 64'd0);

        // Frame 9: timeout fires while clr_in is high; the new bits stick.
        push_exp(9, 16, 1'b1, 2'b11, 9);
        tick();
        repeat (15) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("set_beats_clr", 64'(timed_out_ch_out), 64'b11);

        // Frame 10: switch to hold mid-frame; the frame still finishes.
        push_exp(10, 16, 1'b1, 2'b11, 10);
        tick();
        mode = 2'd2;
        for (int n = 0; n < 40 && busy_out; n++) tick();
        check_eq("hold_after_frame", 64'(busy_out), 64'd0);
        base = start_cnt;
        repeat (4) tick();
        check_eq("hold_no_start", 64'(start_cnt - base), 64'd0);

        // Mid-frame reset, then a fresh launch.
        mode = 2'd0;
        wait_start(5);
        repeat (4) tick();
        check_eq("pre_reset_busy", 64'(busy_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        wait_start(5);
        push_exp(1, 3, 1'b0, 2'b00, 1);
        tick();
        check_eq("post_reset_timer", 64'(timer_out), 64'd1);
        repeat (2) tick();
        done = 2'b11; mode = 2'd2;
        tick();
        done = 2'b00;
        check_eq("post_reset_fcnt", 64'(frame_count_out), 64'd1);
        repeat (3) tick();

        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
